pipe_hazard_ctrl: RTL



---
 rtl/pipe_pkg.sv | 32 +++
 rtl/pipe_hazard_ctrl_if.sv | 50 +++++
 rtl/pipe_hazard_match.sv | 47 ++++
 rtl/pipe_hazard_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared types for the pipeline hazard controller:
//   state_t        - controller state (IDLE, MD_BUSY)
//   stage_entry_t  - shadow record kept for every in-flight instruction after D
//   ENTRY_NONE     - an invalid entry (a bubble)
//   SEL_NONE       - bypass select code meaning "use the DX register value"
// -----------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    // The record carries the widest register index any instance may use. A
    // narrower REG_BITS is zero-extended into it, so the upper bits stay
    // constant and cost nothing.
    localparam int MAX_REG_BITS = 8;

    typedef struct packed {
        logic                    valid;
        logic                    writes;
        logic                    is_load;
        logic [MAX_REG_BITS-1:0] rd;
    } stage_entry_t;

    localparam stage_entry_t ENTRY_NONE = '0;

    localparam int SEL_NONE = 0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundle between the pipeline datapath (master) and the hazard controller
// (slave).
//   master drives : d_valid, d_rs1, d_rs2, d_rd, d_use_rs1, d_use_rs2,
//                   d_writes, d_is_load, d_is_md, x_redirect, md_ready
//   slave drives  : stall_fd, flush_fd, bubble_dx, hold_dx, md_start,
//                   byp_sel_a, byp_sel_b, rf_fwd_a, rf_fwd_b, perf_stall_cnt
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
    parameter int REG_BITS = 5,
    parameter int SELW     = 2
);
    logic                d_valid;
    logic [REG_BITS-1:0] d_rs1;
    logic [REG_BITS-1:0] d_rs2;
    logic [REG_BITS-1:0] d_rd;
    logic                d_use_rs1;
    logic                d_use_rs2;
    logic                d_writes;
    logic                d_is_load;
    logic                d_is_md;
    logic                x_redirect;
    logic                md_ready;

    logic                stall_fd;
    logic                flush_fd;
    logic                bubble_dx;
    logic                hold_dx;
    logic                md_start;
    logic [SELW-1:0]     byp_sel_a;
    logic [SELW-1:0]     byp_sel_b;
    logic                rf_fwd_a;
    logic                rf_fwd_b;
    logic [31:0]         perf_stall_cnt;

    modport master (
        output d_valid, d_rs1, d_rs2, d_rd, d_use_rs1, d_use_rs2,
               d_writes, d_is_load, d_is_md, x_redirect, md_ready,
        input  stall_fd, flush_fd, bubble_dx, hold_dx, md_start,
               byp_sel_a, byp_sel_b, rf_fwd_a, rf_fwd_b, perf_stall_cnt
    );

    modport slave (
        input  d_valid, d_rs1, d_rs2, d_rd, d_use_rs1, d_use_rs2,
               d_writes, d_is_load, d_is_md, x_redirect, md_ready,
        output stall_fd, flush_fd, bubble_dx, hold_dx, md_start,
               byp_sel_a, byp_sel_b, rf_fwd_a, rf_fwd_b, perf_stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_match.sv
// -----------------------------------------------------------------------------
// pipe_hazard_match
// Compares one decode source operand against every tracked stage entry.
//   src, use_src   in  operand index and "operand is really read" (already
//                      qualified with d_valid by the caller)
//   entries        in  shadow entries, index 1 = X ... STAGES = W
//   hit            out some stage produces src
//   near_k         out smallest matching stage index (0 when no hit)
//   load_blocked   out nearest producer is a load not yet forwardable
// -----------------------------------------------------------------------------
module pipe_hazard_match
    import pipe_pkg::*;
#(
    parameter int STAGES     = 3,
    parameter int REG_BITS   = 5,
    parameter int LOAD_READY = 3,
    parameter int SELW       = $clog2(STAGES + 1)
) (
    input  logic [REG_BITS-1:0] src,
    input  logic                use_src,
    input  stage_entry_t        entries [1:STAGES],
    output logic                hit,
    output logic [SELW-1:0]     near_k,
    output logic                load_blocked
);

    // NOTE: every output gets a default before the loop; a path that leaves a
    // combinational output unassigned would infer a latch.
    always_comb begin
        hit          = 1'b0;
        near_k       = '0;
        load_blocked = 1'b0;
        // Scan oldest to youngest so the youngest (nearest) producer is the
        // last one written and therefore wins.
        for (int k = STAGES; k >= 1; k--) begin
            if (use_src && (src != '0) && entries[k].valid && entries[k].writes &&
                (entries[k].rd == MAX_REG_BITS'(src))) begin
                hit          = 1'b1;
                near_k       = SELW'(k);
                // After the D->X move the producer sits in stage k+1; it only
                // has data once that stage reaches LOAD_READY.
                load_blocked = entries[k].is_load && ((k + 1) < LOAD_READY);
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard, bypass and stall controller for the in-order pipeline. Keeps a
// shadow shift register of the destination of every post-decode instruction
// and drives the enable/clear controls of the FD/DX/XM/MW latches.
//   clock, reset  in  master clock, synchronous active-high reset
//   bus           slave side of pipe_hazard_ctrl_if (decode attributes,
//                 redirect, multdiv handshake in; stall/flush/bubble/hold,
//                 md_start, bypass selects, rf forwarding, stall counter out)
// REG_BITS must not exceed pipe_pkg::MAX_REG_BITS and must match the bus.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int STAGES     = 3,
    parameter int REG_BITS   = 5,
    parameter int LOAD_READY = 3,
    parameter int SELW       = $clog2(STAGES + 1)
) (
    input  logic               clock,
    input  logic               reset,
    pipe_hazard_ctrl_if.slave  bus
);

    stage_entry_t    stage_q [1:STAGES];
    stage_entry_t    d_entry;
    state_t          state_q, state_d;

    logic            hit_a, hit_b, blk_a, blk_b;
    logic [SELW-1:0] near_a, near_b;
    logic [SELW-1:0] sel_a_d, sel_b_d, sel_a_q, sel_b_q;
    logic            load_use;
    logic            stall_fd, flush_fd, bubble_dx, hold_dx, md_start;
    logic [31:0]     stall_cnt_q;

    assign d_entry = '{valid:   bus.d_valid,
                       writes:  bus.d_writes,
                       is_load: bus.d_is_load,
                       rd:      MAX_REG_BITS'(bus.d_rd)};

    pipe_hazard_match #(
        .STAGES(STAGES), .REG_BITS(REG_BITS), .LOAD_READY(LOAD_READY), .SELW(SELW)
    ) u_match_a (
        .src(bus.d_rs1), .use_src(bus.d_valid & bus.d_use_rs1), .entries(stage_q),
        .hit(hit_a), .near_k(near_a), .load_blocked(blk_a)
    );

    pipe_hazard_match #(
        .STAGES(STAGES), .REG_BITS(REG_BITS), .LOAD_READY(LOAD_READY), .SELW(SELW)
    ) u_match_b (
        .src(bus.d_rs2), .use_src(bus.d_valid & bus.d_use_rs2), .entries(stage_q),
        .hit(hit_b), .near_k(near_b), .load_blocked(blk_b)
    );

    assign load_use = blk_a | blk_b;

    // A producer still inside the bypass network is reached through stage k+1
    // once the consumer enters X; one already in W is read through the
    // regfile write port during D instead.
    assign sel_a_d = (hit_a && (near_a < SELW'(STAGES))) ? near_a + SELW'(1) : SELW'(SEL_NONE);
    assign sel_b_d = (hit_b && (near_b < SELW'(STAGES))) ? near_b + SELW'(1) : SELW'(SEL_NONE);

    always_comb begin
        state_d   = state_q;
        stall_fd  = 1'b0;
        flush_fd  = 1'b0;
        bubble_dx = 1'b0;
        hold_dx   = 1'b0;
        md_start  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.x_redirect) begin
                    // The D instruction is on the wrong path, so any load-use
                    // stall it would cause is moot.
                    flush_fd  = 1'b1;
                    bubble_dx = 1'b1;
                end else if (load_use) begin
                    stall_fd  = 1'b1;
                    bubble_dx = 1'b1;
                end else if (bus.d_valid && bus.d_is_md) begin
                    md_start = 1'b1;
                    state_d  = MD_BUSY;
                end
            end
            MD_BUSY: begin
                // Redirects cannot occur while X is frozen on the multdiv op.
                stall_fd = 1'b1;
                hold_dx  = 1'b1;
                if (bus.md_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the shadow entries are flops, not RAM, and their valid bits gate
    // every match, so all of them are cleared on reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 1; k <= STAGES; k++) begin
                stage_q[k] <= ENTRY_NONE;
            end
        end else begin
            // While X is held, a bubble opens behind it in stage 2.
            for (int k = 2; k <= STAGES; k++) begin
                stage_q[k] <= (hold_dx && (k == 2)) ? ENTRY_NONE : stage_q[k-1];
            end
            if (!hold_dx) begin
                stage_q[1] <= bubble_dx ? ENTRY_NONE : d_entry;
            end
        end
    end

    // Selects belong to whatever sits in X: frozen with it, cleared by a bubble.
    always_ff @(posedge clock) begin
        if (reset) begin
            sel_a_q <= SELW'(SEL_NONE);
            sel_b_q <= SELW'(SEL_NONE);
        end else if (!hold_dx) begin
            sel_a_q <= bubble_dx ? SELW'(SEL_NONE) : sel_a_d;
            sel_b_q <= bubble_dx ? SELW'(SEL_NONE) : sel_b_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (stall_fd && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign bus.stall_fd       = stall_fd;
    assign bus.flush_fd       = flush_fd;
    assign bus.bubble_dx      = bubble_dx;
    assign bus.hold_dx        = hold_dx;
    assign bus.md_start       = md_start;
    assign bus.byp_sel_a      = sel_a_q;
    assign bus.byp_sel_b      = sel_b_q;
    assign bus.rf_fwd_a       = hit_a && (near_a == SELW'(STAGES));
    assign bus.rf_fwd_b       = hit_b && (near_b == SELW'(STAGES));
    assign bus.perf_stall_cnt = stall_cnt_q;

endmodule
